// File: rtl/timeslice_rr_pkg.sv
// -----------------------------------------------------------------------------
// timeslice_rr_pkg
// Shared definitions for the time-slice round-robin scheduler:
//   - state_t          : arbiter FSM state encoding (IDLE, GRANT, HANDOFF)
//   - DEFAULT_N        : default number of requesters
//   - DEFAULT_TS_WIDTH : default width of the slice length / slice counter
//   - ptr_width()      : width of an index into N requesters (at least 1)
// -----------------------------------------------------------------------------
package timeslice_rr_pkg;

    localparam int DEFAULT_N        = 4;
    localparam int DEFAULT_TS_WIDTH = 4;

    // IDLE    : nobody owns the resource
    // GRANT   : exactly one owner, grant bit visible
    // HANDOFF : one dead cycle between owners, grant is zero
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HANDOFF = 2'd2
    } state_t;

    // Index width for N requesters; a single requester still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority search. Starting at ptr and moving upward
// modulo N, returns the first requester whose req bit is set.
// Ports:
//   req   [N-1:0]  : request vector
//   ptr   [PW-1:0] : index with highest priority this round (must be < N)
//   found          : at least one req bit is set
//   idx   [PW-1:0] : index of the winner (0 when found=0)
// -----------------------------------------------------------------------------
module rr_pick
    import timeslice_rr_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);

    // cand[k] is the requester index examined at priority offset k,
    // i.e. (ptr + k) mod N. ptr < N, so one conditional subtract suffices.
    logic [PW-1:0] cand [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [PW:0] sum;
            assign sum      = {1'b0, ptr} + (PW+1)'(gi);
            assign cand[gi] = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N))
                                                  : PW'(sum);
        end
    endgenerate

    // Walk from the lowest priority offset to the highest so the last hit,
    // which is the smallest offset from ptr, wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/timeslice_rr_scheduler.sv
// -----------------------------------------------------------------------------
// timeslice_rr_scheduler
// Round-robin arbiter with a per-grant time slice. The owner keeps the
// resource while it requests, up to slice_len cycles (0 = unlimited). Every
// grant ends with one HANDOFF cycle where grant is zero; a timeout ending is
// flagged by a one-cycle expired pulse during that HANDOFF cycle.
// Ports:
//   clk                 : clock, all state changes on rising edge
//   reset               : synchronous active-high reset
//   req       [N-1:0]   : per-requester request level
//   slice_len [TS-1:0]  : max grant length in cycles, 0 = unlimited
//   grant     [N-1:0]   : registered one-hot (or zero) grant
//   grant_id  [PW-1:0]  : index of current owner, valid while busy=1
//   busy                : grant is non-zero
//   expired             : grant just ended by slice timeout
// -----------------------------------------------------------------------------
module timeslice_rr_scheduler
    import timeslice_rr_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int TS_WIDTH = DEFAULT_TS_WIDTH,
    parameter int PW       = ptr_width(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req,
    input  logic [TS_WIDTH-1:0] slice_len,
    output logic [N-1:0]        grant,
    output logic [PW-1:0]       grant_id,
    output logic                busy,
    output logic                expired
);

    state_t              state_reg,     state_next;
    logic [PW-1:0]       ptr_reg,       ptr_next;
    logic [PW-1:0]       owner_reg,     owner_next;
    logic [TS_WIDTH-1:0] slice_cnt_reg, slice_cnt_next;
    logic [TS_WIDTH-1:0] slice_lat_reg, slice_lat_next;
    logic [N-1:0]        grant_reg,     grant_next;
    logic                expired_reg,   expired_next;

    logic                pick_found;
    logic [PW-1:0]       pick_idx;
    logic [PW-1:0]       ptr_after_owner;
    logic                slice_done;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Priority moves to the requester just above the outgoing owner.
    assign ptr_after_owner = (owner_reg == PW'(N - 1)) ? '0 : owner_reg + PW'(1);

    // Timeout only applies to a limited slice; slice_lat=0 never expires.
    assign slice_done = (slice_lat_reg != '0) && (slice_cnt_reg == slice_lat_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            slice_cnt_reg <= '0;
            slice_lat_reg <= '0;
            grant_reg     <= '0;
            expired_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            owner_reg     <= owner_next;
            slice_cnt_reg <= slice_cnt_next;
            slice_lat_reg <= slice_lat_next;
            grant_reg     <= grant_next;
            expired_reg   <= expired_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        owner_next     = owner_reg;
        slice_cnt_next = slice_cnt_reg;
        slice_lat_next = slice_lat_reg;
        grant_next     = grant_reg;
        expired_next   = 1'b0;

        case (state_reg)
            IDLE, HANDOFF: begin
                if (pick_found) begin
                    state_next     = GRANT;
                    owner_next     = pick_idx;
                    grant_next     = N'(1) << pick_idx;
                    // Slice length is frozen for the whole grant.
                    slice_lat_next = slice_len;
                    slice_cnt_next = TS_WIDTH'(1);
                end else begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end

            GRANT: begin
                if (!req[owner_reg]) begin
                    // A dropped request wins over a coincident timeout.
                    state_next = HANDOFF;
                    grant_next = '0;
                    ptr_next   = ptr_after_owner;
                end else if (slice_done) begin
                    state_next   = HANDOFF;
                    grant_next   = '0;
                    expired_next = 1'b1;
                    ptr_next     = ptr_after_owner;
                end else if (slice_cnt_reg != '1) begin
                    slice_cnt_next = slice_cnt_reg + TS_WIDTH'(1);
                end
            end

            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    assign grant    = grant_reg;
    assign grant_id = owner_reg;
    assign busy     = |grant_reg;
    assign expired  = expired_reg;

endmodule
